// File: rtl/perf_counter_bank_pkg.sv
// perf_counter_pkg: shared counter-mode constants and select-width helper.
package perf_counter_pkg;

    localparam int MODE_WRAP = 0;
    localparam int MODE_SAT  = 1;

    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/perf_counter_bank_channel.sv
// perf_counter_channel: one gated event counter with sticky overflow flag.
module perf_counter_channel
    import perf_counter_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int SATURATE = MODE_WRAP
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] cnt,
    output logic             ovf
);

    logic full;

    assign full = &cnt;

    always_ff @(posedge CLK) begin
        if (Reset || clr) begin
            cnt <= '0;
            ovf <= 1'b0;
        end else if (inc) begin
            cnt <= (full && SATURATE == MODE_SAT) ? cnt : cnt + WIDTH'(1);
            ovf <= ovf | full;
        end
    end

endmodule

// File: rtl/perf_counter_bank.sv
// perf_counter_bank: free-running cycle counter plus NUM_CH event counters
// with bank-wide snapshot shadows and a registered read port.
module perf_counter_bank
    import perf_counter_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int NUM_CH   = 4,
    parameter int SATURATE = MODE_WRAP,
    parameter int RDSEL_W  = 0,
    localparam int SELW    = (RDSEL_W > 0) ? RDSEL_W : sel_width(NUM_CH)
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic              Enable,
    input  logic [NUM_CH-1:0] Event,
    input  logic [NUM_CH-1:0] Clear,
    input  logic              Snapshot,
    input  logic [SELW-1:0]   RdSel,
    input  logic              RdShadow,
    output logic [WIDTH-1:0]  RdData,
    output logic [NUM_CH-1:0] Overflow,
    output logic [WIDTH-1:0]  CycleCount
);

    localparam int IW = sel_width(NUM_CH);

    logic [WIDTH-1:0] cnt    [NUM_CH];
    logic [WIDTH-1:0] shadow [NUM_CH];
    logic [WIDTH-1:0] rd_next;
    logic [IW-1:0]    idx;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        perf_counter_channel #(
            .WIDTH    (WIDTH),
            .SATURATE (SATURATE)
        ) u_ch (
            .CLK   (CLK),
            .Reset (Reset),
            .inc   (Enable & Event[i]),
            .clr   (Clear[i]),
            .cnt   (cnt[i]),
            .ovf   (Overflow[i])
        );
    end

    // Out-of-range selects are masked before the index is used.
    assign idx = IW'(RdSel);

    always_comb begin
        rd_next = (int'(RdSel) < NUM_CH) ? (RdShadow ? shadow[idx] : cnt[idx]) : '0;
    end

    always_ff @(posedge CLK) begin
        CycleCount <= Reset ? '0 : CycleCount + WIDTH'(1);
        RdData     <= Reset ? '0 : rd_next;
        for (int k = 0; k < NUM_CH; k++)
            shadow[k] <= Reset ? '0 : Snapshot ? cnt[k] : shadow[k];
    end

endmodule
